// File: rtl/jtdsp16_sio2.sv
// jtdsp16_sio2: DSP16 serial I/O unit, JTDSP16_SIO_SADD_EN adds the serial address shifter
module jtdsp16_sio2 #(
    parameter int DW     = 16,
    parameter int CLKDIV = 12,
    parameter int AW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    output logic          ock,
    output logic          sio_do,
    output logic          old,
    output logic          ose,
    input  logic          ick,
    input  logic          ild,
    input  logic          sio_di,
    input  logic [DW-1:0] wr_data,
    input  logic          sio_wr,
    input  logic          sio_rd,
    input  logic [2:0]    r_field,
    output logic [DW-1:0] r_sio,
    output logic          obe,
    output logic          ibf,
    output logic          oovr,
    output logic          sadd
);
    localparam int HW = DW / 2;
    localparam int CW = $clog2(CLKDIV);
    localparam int BW = $clog2(DW + 1);

    logic [CW-1:0] clkdiv;
    logic [9:0]    sioc;
    logic [AW-1:0] srta;
    logic [DW-1:0] obuf, osr, isr, ibuf;
    logic [BW-1:0] ocnt, icnt;
    logic          ock_l, ick_l, first;
    logic          msb, wr_sioc, wr_srta, wr_sdx, rd_sdx, edge_o, edge_i;
    logic          xfer, last, reload, done, step, cap, pick;
    logic [BW-1:0] olen, ilen;
    logic [DW-1:0] ld, cur, nxt, nisr, capv;

    always_comb begin
        msb     = sioc[6];
        olen    = sioc[1] ? BW'(HW) : BW'(DW);
        ilen    = sioc[0] ? BW'(HW) : BW'(DW);
        wr_sioc = sio_wr && r_field == 3'd0;
        wr_srta = sio_wr && r_field == 3'd1;
        wr_sdx  = sio_wr && r_field == 3'd2;
        rd_sdx  = sio_rd && r_field == 3'd2;
        edge_o  = ock && !ock_l && !ose;
        xfer    = ose && !obe;
        last    = edge_o && !first && ocnt == '0;
        reload  = last && !obe;
        done    = last && obe;
        step    = edge_o && !first && !done;
        ld      = msb && sioc[1] ? {obuf[HW-1:0], {HW{1'b0}}} : obuf;
        cur     = reload ? ld : osr;
        pick    = msb ? cur[DW-1] : cur[0];
        nxt     = msb ? cur << 1 : cur >> 1;
        edge_i  = ick && !ick_l && !ild;
        nisr    = msb ? {isr[DW-2:0], sio_di} : {sio_di, isr[DW-1:1]};
        cap     = edge_i && icnt + BW'(1) == ilen;
        capv    = !sioc[0] ? nisr : msb ? {{HW{1'b0}}, nisr[HW-1:0]} : {{HW{1'b0}}, nisr[DW-1:HW]};
        r_sio   = r_field == 3'd0 ? DW'(sioc) : r_field == 3'd1 ? DW'(srta) : r_field == 3'd2 ? ibuf : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clkdiv <= '0;
            ock    <= 1'b0;
            ock_l  <= 1'b0;
            ick_l  <= 1'b0;
            sio_do <= 1'b0;
            old    <= 1'b1;
            ose    <= 1'b1;
            obe    <= 1'b1;
            ibf    <= 1'b0;
            oovr   <= 1'b0;
            first  <= 1'b0;
            sioc   <= '0;
            srta   <= '0;
            obuf   <= '0;
            osr    <= '0;
            isr    <= '0;
            ibuf   <= '0;
            ocnt   <= '0;
            icnt   <= '0;
        end else if (cen) begin
            clkdiv <= clkdiv == CW'(CLKDIV - 1) ? '0 : clkdiv + CW'(1);
            if (clkdiv == CW'(CLKDIV / 2 - 1)) ock <= !ose;
            if (clkdiv == CW'(CLKDIV - 1)) ock <= 1'b0;
            ock_l <= ock;
            ick_l <= ick;
            if (wr_sioc) begin
                sioc <= wr_data[9:0];
                oovr <= 1'b0;
            end
            if (wr_srta) srta <= wr_data[AW-1:0];
            if (xfer) begin
                osr   <= ld;
                ocnt  <= olen;
                obe   <= 1'b1;
                ose   <= 1'b0;
                first <= 1'b1;
            end
            if (edge_o && first) begin
                old   <= 1'b0;
                first <= 1'b0;
            end
            if (step) begin
                sio_do <= pick;
                osr    <= nxt;
                ocnt   <= (reload ? olen : ocnt) - BW'(1);
            end
            if (reload) obe <= 1'b1;
            if (done) begin
                ose <= 1'b1;
                old <= 1'b1;
            end
            if (wr_sdx) begin
                obuf <= wr_data;
                obe  <= 1'b0;
                if (!obe) oovr <= 1'b1;
            end
            if (ild) icnt <= '0;
            else if (edge_i) begin
                isr  <= nisr;
                icnt <= cap ? '0 : icnt + BW'(1);
            end
            if (rd_sdx) ibf <= 1'b0;
            if (cap) begin
                ibuf <= capv;
                ibf  <= 1'b1;
            end
        end
    end

`ifdef JTDSP16_SIO_SADD_EN
    logic [AW-1:0] asr, acur;
    logic          sadd_r;

    always_comb begin
        acur = reload ? srta : asr;
        sadd = sadd_r && !ose;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asr    <= '0;
            sadd_r <= 1'b0;
        end else if (cen) begin
            if (xfer) begin
                asr    <= srta;
                sadd_r <= 1'b0;
            end
            if (step) begin
                sadd_r <= acur[AW-1];
                asr    <= {acur[AW-2:0], 1'b1};
            end
        end
    end
`else
    always_comb sadd = 1'b0;
`endif
endmodule
